// File: rtl/fifo_drain_reader_pkg.sv
// Shared widths, batch size and controller state encoding for the
// result-FIFO drain reader.
package fifo_drain_reader_pkg;

  localparam int unsigned DRAIN_DW    = 21;
  localparam int unsigned DRAIN_BATCH = 4;
  localparam int unsigned DRAIN_CW    = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHECK   = 3'd1,
    ST_READ    = 3'd2,
    ST_LATCH   = 3'd3,
    ST_PRESENT = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

endpackage

// File: rtl/fifo_drain_reader_rd_counter.sv
// Per-batch word counter: ld clears, en increments, term flags the last
// word of a batch (count == BATCH-1).
module rd_counter #(
  parameter int unsigned CW    = 3,
  parameter int unsigned BATCH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          term
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count; the BATCH guard keeps the count bounded even if en misfires.
  always_comb begin
    cnt_d = cnt_q;
    if (ld) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CW'(BATCH))) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign term = (cnt_q == CW'(BATCH - 1));

endmodule

// File: rtl/fifo_drain_reader.sv
// Consumer of the result FIFO: pops one word at a time, presents it on a
// valid/ready port and signals done after each batch.
module fifo_drain_reader
  import fifo_drain_reader_pkg::*;
#(
  parameter int unsigned DW    = DRAIN_DW,
  parameter int unsigned BATCH = DRAIN_BATCH,
  parameter int unsigned CW    = DRAIN_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          empty,
  input  logic [DW-1:0] q,
  output logic          rdreq,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] word_cnt,
  output logic          done
);

  state_e        state_q;
  state_e        state_d;
  logic [DW-1:0] out_data_q;
  logic [DW-1:0] out_data_d;
  logic          cnt_ld;
  logic          cnt_en;
  logic          cnt_term;

  rd_counter #(
    .CW    (CW),
    .BATCH (BATCH)
  ) u_rd_counter (
    .clk  (clk),
    .rst  (rst),
    .ld   (cnt_ld),
    .en   (cnt_en),
    .cnt  (word_cnt),
    .term (cnt_term)
  );

  // Controller next-state; empty is only trusted in CHECK since we are the sole reader.
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    cnt_ld     = 1'b0;
    cnt_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_ld  = 1'b1;
          state_d = ST_CHECK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (!empty) begin
          state_d = ST_READ;
        end else begin
          state_d = ST_CHECK;
        end
      end
      ST_READ: begin
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        out_data_d = q;
        state_d    = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (out_ready) begin
          cnt_en  = 1'b1;
          state_d = cnt_term ? ST_DONE : ST_CHECK;
        end else begin
          state_d = ST_PRESENT;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and captured-word registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
    end
  end

  assign rdreq     = (state_q == ST_READ);
  assign out_valid = (state_q == ST_PRESENT);
  assign done      = (state_q == ST_DONE);
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_fifo_drain_reader.sv
// Directed bench for fifo_drain_reader with a small behavioural FIFO model.
module tb_fifo_drain_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        out_ready = 1'b1;
  logic [20:0] q = 21'h0;
  logic        empty;
  logic        rdreq;
  logic        out_valid;
  logic        done;
  logic [20:0] out_data;
  logic [2:0]  word_cnt;

  logic [20:0] mem [0:63];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          underflow = 0;
  int          cyc = 0;
  int          rd_cnt = 0;
  int          rd_time[$];
  logic [20:0] got[$];
  int          errors = 0;
  int          checks = 0;

  logic [20:0] batch1 [4];
  logic [20:0] batch2 [4];
  logic [20:0] batch3 [4];

  fifo_drain_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .empty     (empty),
    .q         (q),
    .rdreq     (rdreq),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .word_cnt  (word_cnt),
    .done      (done)
  );

  always #5 clk = ~clk;

  assign empty = (wr_ptr == rd_ptr);

  // FIFO read side (q valid the cycle after rdreq) and output monitor.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rdreq) begin
      rd_cnt <= rd_cnt + 1;
      rd_time.push_back(cyc);
      if (empty) underflow <= underflow + 1;
      else begin
        q      <= mem[rd_ptr[5:0]];
        rd_ptr <= rd_ptr + 1;
      end
    end
    if (!rst && out_valid && out_ready) got.push_back(out_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [20:0] w);
    mem[wr_ptr[5:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n;
    n = 0;
    while (done !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check({"done_", tag}, 32'(done), 32'h1);
  endtask

  initial begin
    int rd0;
    int bt;
    int bg;
    int n;

    batch1 = '{21'h001000, 21'h002000, 21'h004000, 21'h008000};
    batch2 = '{21'h0ABCDE, 21'h100001, 21'h0F0F0F, 21'h1FFFFF};
    batch3 = '{21'h000011, 21'h000022, 21'h000033, 21'h000044};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_rdreq", 32'(rdreq), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_data", 32'(out_data), 32'h0);
    check("rst_cnt", 32'(word_cnt), 32'h0);
    rst = 1'b0;

    // Idle ignores a non-empty FIFO until start
    for (int i = 0; i < 4; i++) push(batch1[i]);
    rd0 = rd_cnt;
    repeat (5) @(negedge clk);
    check("idle_no_rdreq", 32'(rd_cnt - rd0), 32'h0);

    // Full batch
    bt = rd_time.size();
    bg = got.size();
    out_ready = 1'b1;
    pulse_start();
    wait_done("b1", 80);
    check("b1_rd_pulses", 32'(rd_cnt - rd0), 32'h4);
    for (int i = 0; i < 3; i++)
      check("b1_rd_spacing", 32'(rd_time[bt+i+1] - rd_time[bt+i]), 32'h4);
    check("b1_words", 32'(got.size() - bg), 32'h4);
    for (int i = 0; i < 4; i++)
      check("b1_data", 32'(got[bg+i]), 32'(batch1[i]));
    check("b1_cnt", 32'(word_cnt), 32'h4);
    check("b1_valid_low", 32'(out_valid), 32'h0);

    // Done held until start, then restart to idle
    repeat (4) @(negedge clk);
    check("done_held", 32'(done), 32'h1);
    pulse_start();
    check("restart_done_low", 32'(done), 32'h0);
    check("restart_no_valid", 32'(out_valid), 32'h0);
    rd0 = rd_cnt;
    repeat (3) @(negedge clk);
    check("restart_idle", 32'(rd_cnt - rd0), 32'h0);

    // Empty stall, then latency and backpressure on the first word
    bg = got.size();
    pulse_start();
    check("b2_cnt_cleared", 32'(word_cnt), 32'h0);
    rd0 = rd_cnt;
    repeat (20) @(negedge clk);
    check("stall_no_rdreq", 32'(rd_cnt - rd0), 32'h0);
    check("stall_no_underflow", 32'(underflow), 32'h0);
    out_ready = 1'b0;
    push(batch2[0]);
    @(negedge clk);
    check("lat_rdreq_hi", 32'(rdreq), 32'h1);
    @(negedge clk);
    check("lat_rdreq_pulse", 32'(rdreq), 32'h0);
    check("lat_valid_early", 32'(out_valid), 32'h0);
    @(negedge clk);
    check("lat_valid", 32'(out_valid), 32'h1);
    check("lat_data", 32'(out_data), 32'h0ABCDE);
    rd0 = rd_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'h1);
      check("bp_data", 32'(out_data), 32'h0ABCDE);
    end
    check("bp_no_rdreq", 32'(rd_cnt - rd0), 32'h0);
    check("bp_cnt", 32'(word_cnt), 32'h0);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_accept_cnt", 32'(word_cnt), 32'h1);
    check("bp_accept_valid", 32'(out_valid), 32'h0);
    check("bp_one_accept", 32'(got.size() - bg), 32'h1);
    for (int i = 1; i < 4; i++) push(batch2[i]);
    wait_done("b2", 80);
    check("b2_words", 32'(got.size() - bg), 32'h4);
    for (int i = 0; i < 4; i++)
      check("b2_data", 32'(got[bg+i]), 32'(batch2[i]));
    check("b2_cnt", 32'(word_cnt), 32'h4);
    pulse_start();

    // Reset during the READ cycle
    for (int i = 0; i < 4; i++) push(batch1[i]);
    pulse_start();
    n = 0;
    while (rdreq !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("mid_rdreq_seen", 32'(rdreq), 32'h1);
    rst = 1'b1;
    #1;
    check("mid_rst_rdreq", 32'(rdreq), 32'h0);
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_done", 32'(done), 32'h0);
    check("mid_rst_data", 32'(out_data), 32'h0);
    check("mid_rst_cnt", 32'(word_cnt), 32'h0);
    repeat (3) @(negedge clk);
    wr_ptr = rd_ptr;
    rst = 1'b0;

    // After release the FSM waits in idle; a fresh batch drains exactly 4 words
    for (int i = 0; i < 4; i++) push(batch3[i]);
    rd0 = rd_cnt;
    repeat (10) @(negedge clk);
    check("post_rst_idle", 32'(rd_cnt - rd0), 32'h0);
    bg = got.size();
    pulse_start();
    wait_done("b3", 80);
    repeat (6) @(negedge clk);
    check("b3_words", 32'(got.size() - bg), 32'h4);
    for (int i = 0; i < 4; i++)
      check("b3_data", 32'(got[bg+i]), 32'(batch3[i]));
    check("b3_cnt", 32'(word_cnt), 32'h4);
    check("b3_rd_pulses", 32'(rd_cnt - rd0), 32'h4);
    check("no_underflow", 32'(underflow), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_drain_reader.md
Name: fifo_drain_reader

Overview:
- Consumer end of the 21-bit result FIFO. The exponent wrapper writes one batch of shifted results into that FIFO.
- This block pops the words one at a time using the FIFO's rdreq/q protocol: q is valid the cycle after rdreq.
- Each popped word is held on a valid/ready output port for downstream logic (display or serial formatter).
- A batch of BATCH words is followed by a done indication. The done/start handshake mirrors the writer side.

Parameters:
- DW, 21, FIFO word width; matches the wrapper data bus.
- BATCH, 4, words per batch; matches the writer's 2-bit counter wrap.
- CW, 3, word-counter width; must hold 0..BATCH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin draining a batch / acknowledge done.
- empty  input  1  FIFO empty flag.
- q  input  DW  FIFO read data; valid the cycle after rdreq.
- rdreq  output  1  FIFO read request; one-cycle pulse per word.
- out_data  output  DW  captured word.
- out_valid  output  1  out_data holds a word not yet accepted.
- out_ready  input  1  downstream accepts the word when high with out_valid.
- word_cnt  output  CW  words accepted in the current batch.
- done  output  1  batch complete; held until start.

Behaviour:
- Reset (async, immediate): state=IDLE, out_data=0, word_cnt=0. rdreq, out_valid and done are all 0.
- rdreq, out_valid and done are decoded from state only, so they drop in the same instant as rst.
- State IDLE:
  - start=1 -> clear word_cnt, go to CHECK.
  - Otherwise stay in IDLE.
- State CHECK:
  - empty=0 -> go to READ.
  - empty=1 -> stay in CHECK.
  - rdreq is never asserted while in CHECK.
- State READ: rdreq=1 for exactly this one cycle, then go to LATCH.
- State LATCH: out_data <= q, then go to PRESENT.
- State PRESENT: out_valid=1.
  - out_ready=1 -> word_cnt <= word_cnt+1.
  - If word_cnt was BATCH-1, go to DONE; else go to CHECK.
  - out_ready=0 -> stay in PRESENT with out_data frozen; no further rdreq.
- State DONE: done=1.
  - start=1 -> go to IDLE; done drops the next cycle.
  - A new batch then needs a fresh start in IDLE.
- start is ignored in CHECK, READ, LATCH and PRESENT.
- Latency and throughput:
  - empty observed low in CHECK -> out_valid high 3 cycles later.
  - With out_ready held high, minimum spacing is 4 cycles per word.
  - out_valid is high exactly 1 cycle per word when out_ready=1.
- Ordering: words are presented in FIFO order; there is no drop or duplication except on reset.
- Underflow: rdreq is issued only after empty=0 is sampled in CHECK. Rationale: this block is the only reader, so empty cannot rise between CHECK and READ.
- Reset mid-operation: a word popped in READ/LATCH is discarded. The system resets the FIFO together with this block.
- word_cnt saturates by construction; it never exceeds BATCH.

Decomposition:
- Shared include holds localparams DW=21 and BATCH=4, plus the state encodings IDLE, CHECK, READ, LATCH, PRESENT, DONE (3-bit).
- Sub-module rd_counter provides the word count: ld clears, en increments, and a terminal flag is raised at BATCH-1.
- The controller FSM and the out_data register stay in the top module.

Test Plan:
- Reset: pulse rst high for 3 cycles mid-run -> rdreq=0, out_valid=0, done=0, out_data=0, word_cnt=0, each asserted within the same cycle.
- Full batch: preload FIFO with 21'h001000, 21'h002000, 21'h004000, 21'h008000; out_ready=1; start high 1 cycle.
  - Expect exactly 4 single-cycle rdreq pulses, 4 cycles apart.
  - out_data values appear in order.
  - done=1 after the 4th accept, with word_cnt=4.
- Empty stall: start with empty=1 for 20 cycles -> rdreq stays 0. Then write 21'h0ABCDE -> rdreq high 1 cycle after empty falls, out_valid 3 cycles after.
- Backpressure: hold out_ready=0 for 10 cycles in PRESENT -> out_valid stays 1, out_data is unchanged, no rdreq. Raising out_ready gives one accept and word_cnt+1.
- Restart: in DONE, assert start -> done=0 next cycle, state IDLE. A second start drains a new 4-word batch and word_cnt restarts from 0.
- Reset mid-read: assert rst during the READ cycle -> rdreq drops immediately and the FSM is in IDLE after release. After a FIFO reset plus a new 4-word batch, exactly 4 words are output.
